// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 pooling scheduler.
// Window slots index the flattened row-major 5x5 window.
package pool_pkg;

    localparam int PIX_W = 16;
    localparam int WIN_N = 5;

    typedef logic signed [PIX_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        POOL,
        WRITE,
        DONE
    } pool_state_e;

    localparam int SLOT00 = 0;
    localparam int SLOT01 = 1;
    localparam int SLOT10 = WIN_N;
    localparam int SLOT11 = WIN_N + 1;

endpackage

// File: rtl/pool_addr_gen.sv
// Output-pixel counters plus read/write address generation.
// Read addresses are formed from the counters' next value so they can be registered.
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              advance,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [1:0]        k,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last
);

    localparam int OUT_W = IMG_W / 2;
    localparam int OUT_H = IMG_H / 2;
    localparam logic [ADDR_W-1:0] W_A  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] OW_A = ADDR_W'(OUT_W);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] ib_q, ob_q, orow_q, ocol_q;
    logic [ADDR_W-1:0] ib_n, ob_n, orow_n, ocol_n;
    logic [ADDR_W-1:0] off;
    logic              wrap;

    assign wrap = (ocol_q == ADDR_W'(OUT_W - 1));
    assign last = wrap && (orow_q == ADDR_W'(OUT_H - 1));

    always_comb begin
        ib_n   = ib_q;
        ob_n   = ob_q;
        orow_n = orow_q;
        ocol_n = ocol_q;
        if (init) begin
            ib_n   = in_base;
            ob_n   = out_base;
            orow_n = '0;
            ocol_n = '0;
        end else if (advance) begin
            if (last) begin
                orow_n = '0;
                ocol_n = '0;
            end else if (wrap) begin
                ocol_n = '0;
                orow_n = orow_q + ONE;
            end else begin
                ocol_n = ocol_q + ONE;
            end
        end
    end

    always_comb begin
        off = '0;
        unique case (k)
            2'd0: off = '0;
            2'd1: off = ONE;
            2'd2: off = W_A;
            2'd3: off = W_A + ONE;
        endcase
    end

    assign rd_addr = ib_n + ((orow_n << 1) * W_A) + (ocol_n << 1) + off;
    assign wr_addr = ob_q + (orow_q * OW_A) + ocol_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ib_q   <= '0;
            ob_q   <= '0;
            orow_q <= '0;
            ocol_q <= '0;
        end else begin
            ib_q   <= ib_n;
            ob_q   <= ob_n;
            orow_q <= orow_n;
            ocol_q <= ocol_n;
        end
    end

endmodule

// File: rtl/pool2x2_scheduler.sv
// Walks a feature map in 2x2 blocks, feeds the pooling unit and
// writes each pooled pixel to the output buffer.
module pool2x2_scheduler
    import pool_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     in_base,
    input  logic [ADDR_W-1:0]     out_base,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_rd_addr,
    input  logic [DATA_W-1:0]     mem_rd_data,
    output logic                  pool_start,
    output logic [25*DATA_W-1:0]  pool_win,
    input  logic                  pool_finish,
    input  logic [DATA_W-1:0]     pool_pixel,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_ready
);

    localparam int NSLOT = 4;

    pool_state_e       state;
    logic [2:0]        fcnt;
    logic [1:0]        rd_k, pend_k, gen_k;
    logic              pend;
    logic [DATA_W-1:0] win [NSLOT];

    logic              gen_init, gen_adv, gen_last;
    logic [ADDR_W-1:0] gen_rd, gen_wr;

    assign gen_init = (state == IDLE) && start;
    assign gen_adv  = (state == WRITE) && wr_ready;
    assign gen_k    = (state == FETCH) ? fcnt[1:0] + 2'd1 : 2'd0;

    pool_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk      (clk),
        .rst      (rst),
        .init     (gen_init),
        .advance  (gen_adv),
        .in_base  (in_base),
        .out_base (out_base),
        .k        (gen_k),
        .rd_addr  (gen_rd),
        .wr_addr  (gen_wr),
        .last     (gen_last)
    );

    always_comb begin
        pool_win = '0;
        pool_win[SLOT00*DATA_W +: DATA_W] = win[0];
        pool_win[SLOT01*DATA_W +: DATA_W] = win[1];
        pool_win[SLOT10*DATA_W +: DATA_W] = win[2];
        pool_win[SLOT11*DATA_W +: DATA_W] = win[3];
    end

    // Read data lands one cycle after issue; pend/pend_k track that slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            pool_start  <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            fcnt        <= '0;
            rd_k        <= '0;
            pend        <= 1'b0;
            pend_k      <= '0;
            for (int i = 0; i < NSLOT; i++) win[i] <= '0;
        end else begin
            pend   <= mem_rd_en;
            pend_k <= rd_k;
            if (pend) win[pend_k] <= mem_rd_data;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        state       <= FETCH;
                        fcnt        <= '0;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= gen_rd;
                        rd_k        <= 2'd0;
                    end
                end
                FETCH: begin
                    fcnt <= fcnt + 3'd1;
                    if (fcnt < 3'd3) begin
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= gen_rd;
                        rd_k        <= gen_k;
                    end else begin
                        mem_rd_en <= 1'b0;
                    end
                    if (fcnt == 3'd4) begin
                        state      <= POOL;
                        pool_start <= 1'b1;
                    end
                end
                POOL: begin
                    if (pool_finish) begin
                        wr_data    <= pool_pixel;
                        pool_start <= 1'b0;
                        wr_en      <= 1'b1;
                        wr_addr    <= gen_wr;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        wr_en <= 1'b0;
                        if (gen_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state       <= FETCH;
                            fcnt        <= '0;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= gen_rd;
                            rd_k        <= 2'd0;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool2x2_scheduler.sv
// Bench for pool2x2_scheduler: 4x4 and 5x5 instances, RAM, pooling
// and write-sink models, with a queue-based reference of expected traffic.
module tb_pool2x2_scheduler;

    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, sel;
    logic [AW-1:0] in_base, out_base;
    logic [DW-1:0] rd_data, pool_pixel;
    logic          pool_finish, wr_ready;

    logic busy4, done4, rden4, ps4, wen4;
    logic busy5, done5, rden5, ps5, wen5;
    logic [AW-1:0] ra4, wa4, ra5, wa5;
    logic [DW-1:0] wd4, wd5;
    logic [25*DW-1:0] win4, win5;

    logic busy, done, mem_rd_en, pool_start, wr_en;
    logic [AW-1:0] mem_rd_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic [25*DW-1:0] pool_win;

    assign busy        = sel ? busy5 : busy4;
    assign done        = sel ? done5 : done4;
    assign mem_rd_en   = sel ? rden5 : rden4;
    assign mem_rd_addr = sel ? ra5 : ra4;
    assign pool_start  = sel ? ps5 : ps4;
    assign pool_win    = sel ? win5 : win4;
    assign wr_en       = sel ? wen5 : wen4;
    assign wr_addr     = sel ? wa5 : wa4;
    assign wr_data     = sel ? wd5 : wd4;

    pool2x2_scheduler #(.IMG_W(4), .IMG_H(4), .DATA_W(DW), .ADDR_W(AW)) u4 (
        .clk(clk), .rst(rst), .start(start & ~sel),
        .in_base(in_base), .out_base(out_base),
        .busy(busy4), .done(done4),
        .mem_rd_en(rden4), .mem_rd_addr(ra4), .mem_rd_data(rd_data),
        .pool_start(ps4), .pool_win(win4),
        .pool_finish(pool_finish), .pool_pixel(pool_pixel),
        .wr_en(wen4), .wr_addr(wa4), .wr_data(wd4), .wr_ready(wr_ready)
    );

    pool2x2_scheduler #(.IMG_W(5), .IMG_H(5), .DATA_W(DW), .ADDR_W(AW)) u5 (
        .clk(clk), .rst(rst), .start(start & sel),
        .in_base(in_base), .out_base(out_base),
        .busy(busy5), .done(done5),
        .mem_rd_en(rden5), .mem_rd_addr(ra5), .mem_rd_data(rd_data),
        .pool_start(ps5), .pool_win(win5),
        .pool_finish(pool_finish), .pool_pixel(pool_pixel),
        .wr_en(wen5), .wr_addr(wa5), .wr_data(wd5), .wr_ready(wr_ready)
    );

    // Feature RAM: one-cycle read latency.
    logic signed [DW-1:0] mem [1024];
    always @(posedge clk) rd_data <= mem[mem_rd_addr[9:0]];

    // Pooling unit: finish after dly extra cycles of pool_start.
    int dly = 0;
    int pcnt = 0;
    always @(posedge clk) pcnt <= pool_start ? pcnt + 1 : 0;

    function automatic logic [DW-1:0] avg4(input logic [25*DW-1:0] w);
        logic signed [DW-1:0] a, b, c, d;
        int s;
        a = w[0 +: DW];
        b = w[DW +: DW];
        c = w[5*DW +: DW];
        d = w[6*DW +: DW];
        s = a + b + c + d;
        return DW'(s >>> 2);
    endfunction

    assign pool_finish = pool_start && (pcnt >= dly);
    assign pool_pixel  = avg4(pool_win);

    // Write sink with an optional stall on one chosen write.
    int acc_n = 0;
    int scnt = 0;
    int stall_at = -1;
    int stall_len = 0;
    always @(posedge clk) begin
        if (wr_en && wr_ready) begin
            acc_n <= acc_n + 1;
            scnt  <= 0;
        end else if (wr_en) begin
            scnt <= scnt + 1;
        end
    end
    assign wr_ready = !(wr_en && acc_n == stall_at && scnt < stall_len);

    // Monitor: records traffic and protocol observations.
    int cyc = 0, n_done = 0, ps_rise = 0;
    int stab_chk = 0, stab_err = 0, hs_chk = 0, hs_err = 0;
    logic [AW-1:0] wq_a [$];
    logic [DW-1:0] wq_d [$];
    int            wq_c [$];
    logic [AW-1:0] rq [$];
    logic [25*DW-1:0] win_snap;
    logic p_wen = 0, p_wrdy = 0, p_ps = 0, p_fin = 0;
    logic [AW-1:0] p_wa;
    logic [DW-1:0] p_wd;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (wr_en && wr_ready) begin
                wq_a.push_back(wr_addr);
                wq_d.push_back(wr_data);
                wq_c.push_back(cyc);
            end
            if (mem_rd_en) rq.push_back(mem_rd_addr);
            if (done) n_done <= n_done + 1;
            if (p_wen && !p_wrdy) begin
                stab_chk <= stab_chk + 1;
                if (!wr_en || wr_addr !== p_wa || wr_data !== p_wd)
                    stab_err <= stab_err + 1;
            end
            if (p_ps) begin
                hs_chk <= hs_chk + 1;
                if (p_fin == pool_start) hs_err <= hs_err + 1;
            end
            if (!p_ps && pool_start) begin
                ps_rise  <= ps_rise + 1;
                win_snap <= pool_win;
            end
        end
        p_wen  <= wr_en && !rst;
        p_wrdy <= wr_ready;
        p_ps   <= pool_start && !rst;
        p_fin  <= pool_finish;
        p_wa   <= wr_addr;
        p_wd   <= wr_data;
    end

    int asserts = 0;
    int fails = 0;

    task automatic fill_rand();
        for (int i = 0; i < 1024; i++)
            mem[i] = DW'($urandom_range(0, 2000)) - 16'sd1000;
    endtask

    task automatic run_layer(input logic [AW-1:0] ib, input logic [AW-1:0] ob,
                             output int cycles);
        in_base  = ib;
        out_base = ob;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_base  = AW'($urandom);
        out_base = AW'($urandom);
        asserts++;
        if (busy !== 1'b1) begin
            $display("FAIL busy_after_start: got %b want 1", busy);
            fails++;
        end
        cycles = 0;
        while (done !== 1'b1 && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
        asserts++;
        if (done !== 1'b1) begin
            $display("FAIL done_timeout: no done in %0d cycles", cycles);
            fails++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_layer(input int w, input int h, input logic [AW-1:0] ib,
                               input logic [AW-1:0] ob, input int w0, input string tag);
        int ow, oh, n;
        logic [AW-1:0] a, ea;
        logic [DW-1:0] ed;
        int s;
        ow = w / 2;
        oh = h / 2;
        asserts++;
        if (wq_a.size() - w0 != ow * oh) begin
            $display("FAIL %s_write_count: got %0d want %0d", tag, wq_a.size() - w0, ow * oh);
            fails++;
            return;
        end
        n = w0;
        for (int r = 0; r < oh; r++) begin
            for (int c = 0; c < ow; c++) begin
                a  = ib + AW'(2 * r * w + 2 * c);
                s  = mem[a[9:0]] + mem[10'(a + 1)] + mem[10'(a + AW'(w))] + mem[10'(a + AW'(w + 1))];
                ed = DW'(s >>> 2);
                ea = ob + AW'(r * ow + c);
                asserts++;
                if (wq_a[n] !== ea || wq_d[n] !== ed) begin
                    $display("FAIL %s_write[%0d]: got %0d@%0d want %0d@%0d",
                             tag, n - w0, $signed(wq_d[n]), wq_a[n], $signed(ed), ea);
                    fails++;
                end
                n++;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        asserts++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0 || pool_start !== 1'b0 ||
            wr_en !== 1'b0 || mem_rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0 ||
            pool_win !== '0) begin
            $display("FAIL %s: busy=%b done=%b rd=%b ps=%b we=%b ra=%0d wa=%0d wd=%0d win_nz=%b want all 0",
                     tag, busy, done, mem_rd_en, pool_start, wr_en, mem_rd_addr,
                     wr_addr, wr_data, |pool_win);
            fails++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        sel = 1'b0;
        #1 check_idle_outputs("reset_4x4");
        sel = 1'b1;
        #1 check_idle_outputs("reset_5x5");
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_4x4();
        int cycles, w0;
        logic [AW-1:0] ea [4];
        logic [DW-1:0] ed [4];
        logic [25*DW-1:0] ew;
        int vals [16];
        vals = '{10, 20, 30, 40, 50, 60, 70, 80, 1, 2, 3, 4, 5, 6, 7, 8};
        ea = '{16'd100, 16'd101, 16'd102, 16'd103};
        ed = '{16'd35, 16'd55, 16'd3, 16'd5};
        sel = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = DW'(vals[i]);
        w0 = wq_a.size();
        run_layer(16'd0, 16'd100, cycles);
        asserts++;
        if (cycles != 28) begin
            $display("FAIL 4x4_latency: got %0d want 28", cycles);
            fails++;
        end
        asserts++;
        if (wq_a.size() - w0 != 4) begin
            $display("FAIL 4x4_count: got %0d want 4", wq_a.size() - w0);
            fails++;
        end else begin
            for (int i = 0; i < 4; i++) begin
                asserts++;
                if (wq_a[w0+i] !== ea[i] || wq_d[w0+i] !== ed[i]) begin
                    $display("FAIL 4x4_write[%0d]: got %0d@%0d want %0d@%0d",
                             i, wq_d[w0+i], wq_a[w0+i], ed[i], ea[i]);
                    fails++;
                end
            end
        end
        ew = '0;
        ew[0 +: DW]    = 16'd3;
        ew[DW +: DW]   = 16'd4;
        ew[5*DW +: DW] = 16'd7;
        ew[6*DW +: DW] = 16'd8;
        asserts++;
        if (win_snap !== ew) begin
            $display("FAIL 4x4_window: got %h want %h", win_snap, ew);
            fails++;
        end
        asserts++;
        if (busy !== 1'b0) begin
            $display("FAIL 4x4_busy_end: got %b want 0", busy);
            fails++;
        end
    endtask

    task automatic test_5x5();
        int cycles, w0, r0, n;
        logic [AW-1:0] ib, ob, a, off;
        sel = 1'b1;
        fill_rand();
        ib = AW'($urandom_range(0, 500));
        ob = AW'($urandom_range(600, 900));
        w0 = wq_a.size();
        r0 = rq.size();
        run_layer(ib, ob, cycles);
        asserts++;
        if (cycles != 28) begin
            $display("FAIL 5x5_latency: got %0d want 28", cycles);
            fails++;
        end
        check_layer(5, 5, ib, ob, w0, "5x5");
        asserts++;
        if (rq.size() - r0 != 16) begin
            $display("FAIL 5x5_read_count: got %0d want 16", rq.size() - r0);
            fails++;
        end else begin
            n = r0;
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++)
                    for (int k = 0; k < 4; k++) begin
                        a   = ib + AW'((2 * r + k / 2) * 5 + 2 * c + k % 2);
                        off = rq[n] - ib;
                        asserts++;
                        if (rq[n] !== a || off % 5 == 4 || off / 5 == 4) begin
                            $display("FAIL 5x5_read[%0d]: got %0d want %0d", n - r0, rq[n], a);
                            fails++;
                        end
                        n++;
                    end
        end
        sel = 1'b0;
    endtask

    task automatic test_random();
        int cycles, w0;
        logic [AW-1:0] ib, ob;
        sel = 1'b0;
        for (int t = 0; t < 3; t++) begin
            fill_rand();
            ib = AW'($urandom_range(0, 900));
            ob = AW'($urandom);
            w0 = wq_a.size();
            run_layer(ib, ob, cycles);
            check_layer(4, 4, ib, ob, w0, "rand4x4");
        end
    endtask

    task automatic test_stall();
        int cycles, w0, sc0, se0;
        logic [AW-1:0] ib, ob;
        sel = 1'b0;
        fill_rand();
        ib = AW'($urandom_range(0, 900));
        ob = AW'($urandom_range(0, 900));
        stall_at  = acc_n + 1;
        stall_len = 3;
        w0  = wq_a.size();
        sc0 = stab_chk;
        se0 = stab_err;
        run_layer(ib, ob, cycles);
        stall_len = 0;
        asserts++;
        if (cycles != 31) begin
            $display("FAIL stall_latency: got %0d want 31", cycles);
            fails++;
        end
        asserts++;
        if (stab_chk - sc0 != 3 || stab_err != se0) begin
            $display("FAIL stall_stable: checks %0d want 3, errors %0d want 0",
                     stab_chk - sc0, stab_err - se0);
            fails++;
        end
        asserts++;
        if (wq_c.size() - w0 < 2) begin
            $display("FAIL stall_pixel_time: only %0d writes", wq_c.size() - w0);
            fails++;
        end else if (wq_c[w0+1] - wq_c[w0] != 10) begin
            $display("FAIL stall_pixel_time: got %0d want 10", wq_c[w0+1] - wq_c[w0]);
            fails++;
        end
        check_layer(4, 4, ib, ob, w0, "stall");
    endtask

    task automatic test_pool_delay();
        int cycles, w0, hc0, he0;
        logic [AW-1:0] ib, ob;
        sel = 1'b0;
        fill_rand();
        ib  = AW'($urandom_range(0, 900));
        ob  = AW'($urandom);
        dly = 2;
        w0  = wq_a.size();
        hc0 = hs_chk;
        he0 = hs_err;
        run_layer(ib, ob, cycles);
        dly = 0;
        asserts++;
        if (cycles != 36) begin
            $display("FAIL pooldly_latency: got %0d want 36", cycles);
            fails++;
        end
        asserts++;
        if (hs_chk - hc0 != 12 || hs_err != he0) begin
            $display("FAIL pooldly_handshake: pool cycles %0d want 12, errors %0d want 0",
                     hs_chk - hc0, hs_err - he0);
            fails++;
        end
        check_layer(4, 4, ib, ob, w0, "pooldly");
    endtask

    task automatic test_start_while_busy();
        int cycles, w0, d0;
        logic [AW-1:0] ib, ob;
        sel = 1'b0;
        fill_rand();
        ib = AW'($urandom_range(0, 900));
        ob = AW'($urandom);
        w0 = wq_a.size();
        d0 = n_done;
        in_base  = ib;
        out_base = ob;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (done !== 1'b1 && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            start   = (cycles == 5 || cycles == 13 || cycles == 21 || cycles == 28);
            in_base = AW'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        asserts++;
        if (cycles != 28) begin
            $display("FAIL rebusy_latency: got %0d want 28", cycles);
            fails++;
        end
        asserts++;
        if (n_done - d0 != 1 || busy !== 1'b0) begin
            $display("FAIL rebusy_done: dones %0d want 1, busy %b want 0", n_done - d0, busy);
            fails++;
        end
        check_layer(4, 4, ib, ob, w0, "rebusy");
    endtask

    task automatic test_rst_mid();
        int cycles, w0, d0, p0, a0;
        logic [AW-1:0] ib, ob;
        sel = 1'b0;
        fill_rand();
        p0 = ps_rise;
        in_base  = AW'($urandom_range(0, 900));
        out_base = AW'($urandom);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (ps_rise - p0 < 2 && cycles < 100) begin
            @(posedge clk);
            cycles++;
        end
        asserts++;
        if (ps_rise - p0 < 2) begin
            $display("FAIL rst_wait_pool: no second POOL in %0d cycles", cycles);
            fails++;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_idle_outputs("rst_async");
        a0 = wq_a.size();
        d0 = n_done;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        asserts++;
        if (wq_a.size() != a0 || n_done != d0 || busy !== 1'b0) begin
            $display("FAIL rst_quiet: writes %0d dones %0d busy %b want 0 0 0",
                     wq_a.size() - a0, n_done - d0, busy);
            fails++;
        end
        ib = AW'($urandom_range(0, 900));
        ob = AW'($urandom);
        w0 = wq_a.size();
        run_layer(ib, ob, cycles);
        asserts++;
        if (cycles != 28) begin
            $display("FAIL rst_relayer_latency: got %0d want 28", cycles);
            fails++;
        end
        check_layer(4, 4, ib, ob, w0, "rst_relayer");
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        sel      = 1'b0;
        in_base  = '0;
        out_base = '0;
        test_reset();
        test_4x4();
        test_5x5();
        test_random();
        test_stall();
        test_pool_delay();
        test_start_while_busy();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
